dac_sched: RTL and testbench

DAC_SCHED -- requirements
Module: dac_sched

---
 rtl/dac_sched_if.sv | 35 +++
 rtl/dac_sched.sv | 183 ++++++++++++++++++
 tb/tb_dac_sched.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_sched_if.sv
// dac_sched_if: bundles the requester write port, the dacsend handshake and the
// status outputs of dac_sched.
//   master : environment side (requester + dacsend), drives writes and handshake replies.
//   slave  : dac_sched side, drives the DAC word, trigger and status.
// Signals:
//   wr_en/wr_ch/wr_data       setpoint write strobe, channel, value
//   data/address/command      word presented to dacsend
//   dactrigsync               transfer request to dacsend
//   dactrigsyncack            dacsend acknowledge (already synchronised)
//   dacdonesync               dacsend completion pulse (already synchronised)
//   pending/busy/err          per-channel dirty flags, FSM busy, sticky timeout flag
interface dac_sched_if;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [11:0] wr_data;
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;
    logic        dactrigsync;
    logic        dactrigsyncack;
    logic        dacdonesync;
    logic [3:0]  pending;
    logic        busy;
    logic        err;

    modport master (
        output wr_en, wr_ch, wr_data, dactrigsyncack, dacdonesync,
        input  data, address, command, dactrigsync, pending, busy, err
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, dactrigsyncack, dacdonesync,
        output data, address, command, dactrigsync, pending, busy, err
    );
endinterface

// File: rtl/dac_sched.sv
// dac_sched: four-channel DAC setpoint scheduler. Holds one 12-bit setpoint per channel,
// marks written channels pending, and dispatches them one at a time to dacsend through a
// trigger/acknowledge/done handshake, picking channels round-robin after the last one sent.
// Optional feature macro: DAC_SCHED_TIMEOUT_EN adds a per-phase timeout (parameter TIMEOUT)
// that aborts a stuck handshake, sets the sticky err flag and re-queues the channel.
// Ports:
//   CLK50MHZ  sole clock, rising edge
//   RST       synchronous active-high reset
//   bus_io    dac_sched_if.slave: write port, dacsend handshake, pending/busy/err status
module dac_sched #(
`ifdef DAC_SCHED_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 1024,
`endif
    parameter logic [3:0]  CMD     = 4'b0011
) (
    input logic        CLK50MHZ,
    input logic        RST,
    dac_sched_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StTrig, StWaitDone} state_e;

    state_e      state_q, state_d;
    logic [11:0] setpoint_q [4];
    logic [11:0] setpoint_d [4];
    logic [3:0]  pending_q, pending_d;
    logic [11:0] data_q, data_d;
    logic [3:0]  addr_q, addr_d;
    logic        trig_q, trig_d;
    logic [1:0]  cur_q, cur_d;
    logic [1:0]  last_q, last_d;

    logic        sel_found;
    logic [1:0]  sel_ch;
    logic [1:0]  cand;
    logic [3:0]  clr_pend;
    logic [3:0]  set_pend;
    logic [3:0]  wr_mask;

`ifdef DAC_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            expired;
    assign expired = (cnt_q == CntW'(TIMEOUT - 1));
`endif

    // Round-robin pick: first pending channel starting at last_sent + 1.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    assign wr_mask = bus_io.wr_en ? (4'b0001 << bus_io.wr_ch) : 4'b0000;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            setpoint_d[i] = setpoint_q[i];
        end
        if (bus_io.wr_en) begin
            setpoint_d[bus_io.wr_ch] = bus_io.wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        addr_d   = addr_q;
        trig_d   = trig_q;
        cur_d    = cur_q;
        last_d   = last_q;
        clr_pend = '0;
        set_pend = '0;
`ifdef DAC_SCHED_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    data_d           = setpoint_q[sel_ch];
                    addr_d           = {2'b00, sel_ch};
                    cur_d            = sel_ch;
                    clr_pend[sel_ch] = 1'b1;
                    trig_d           = 1'b1;
                    state_d          = StTrig;
`ifdef DAC_SCHED_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            StTrig: begin
                if (bus_io.dactrigsyncack) begin
                    trig_d  = 1'b0;
                    state_d = StWaitDone;
`ifdef DAC_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (expired) begin
                    trig_d          = 1'b0;
                    err_d           = 1'b1;
                    set_pend[cur_q] = 1'b1;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StWaitDone: begin
                if (bus_io.dacdonesync) begin
                    last_d  = cur_q;
                    state_d = StIdle;
`ifdef DAC_SCHED_TIMEOUT_EN
                end else if (expired) begin
                    err_d           = 1'b1;
                    set_pend[cur_q] = 1'b1;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A write landing on the dispatch edge wins over the clear, so the channel is resent.
    assign pending_d = (pending_q & ~clr_pend) | set_pend | wr_mask;

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q   <= StIdle;
            for (int i = 0; i < 4; i++) begin
                setpoint_q[i] <= '0;
            end
            pending_q <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            trig_q    <= 1'b0;
            cur_q     <= '0;
            last_q    <= 2'd3;
`ifdef DAC_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < 4; i++) begin
                setpoint_q[i] <= setpoint_d[i];
            end
            pending_q <= pending_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            trig_q    <= trig_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
`ifdef DAC_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus_io.data        = data_q;
    assign bus_io.address     = addr_q;
    assign bus_io.command     = CMD;
    assign bus_io.dactrigsync = trig_q;
    assign bus_io.pending     = pending_q;
    assign bus_io.busy        = (state_q != StIdle);
`ifdef DAC_SCHED_TIMEOUT_EN
    assign bus_io.err         = err_q;
`else
    assign bus_io.err         = 1'b0;
`endif

endmodule

// File: tb/tb_dac_sched.sv
`timescale 1ns/1ps
module tb_dac_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    dac_sched_if bus ();

    dac_sched #(
`ifdef DAC_SCHED_TIMEOUT_EN
        .TIMEOUT(16),
`endif
        .CMD(4'b0011)
    ) u_dut (
        .CLK50MHZ(clk),
        .RST(rst),
        .bus_io(bus)
    );

    // dacsend reply lines: automatic responder OR manual drive from the main sequence.
    logic resp_ack  = 1'b0;
    logic resp_done = 1'b0;
    logic man_ack   = 1'b0;
    logic man_done  = 1'b0;
    assign bus.dactrigsyncack = resp_ack | man_ack;
    assign bus.dacdonesync    = resp_done | man_done;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
    } xfer_t;

    typedef struct {
        logic [1:0]  ch;
        logic [11:0] val;
        int          ack_d;
        int          done_d;
        logic [3:0]  exp_addr;
        logic [11:0] exp_data;
    } vec_t;

    xfer_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    xfer_cnt = 0;
    int    ack_dly  = 1;
    int    done_dly = 2;
    bit    resp_en  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [11:0] d);
        xfer_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic do_write(input logic [1:0] ch, input logic [11:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = ch;
        bus.wr_data = v;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 400 && (bus.busy || bus.pending != 4'h0 || exp_q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.busy || bus.pending != 4'h0 || exp_q.size() != 0), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_trig(input string name);
        int n = 0;
        while (n < 20 && !bus.dactrigsync) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.dactrigsync), 32'd1);
    endtask

    task automatic wait_xfers(input int target, input string name);
        int n = 0;
        while (n < 400 && xfer_cnt < target) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(xfer_cnt >= target), 32'd1);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    // dacsend model + scoreboard consumer.
    initial begin
        xfer_t       e;
        logic [11:0] d0;
        logic [3:0]  a0;
        int          n;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && bus.dactrigsync) begin
                xfer_cnt++;
                d0 = bus.data;
                a0 = bus.address;
                check("xfer_cmd", 32'(bus.command), 32'h3);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: got addr 0x%0h data 0x%0h, expected none",
                             a0, d0);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_addr", 32'(a0), 32'(e.addr));
                    check("xfer_data", 32'(d0), 32'(e.data));
                end
                repeat (ack_dly) @(negedge clk);
                resp_ack = 1'b1;
                n = 0;
                while (bus.dactrigsync && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("trig_drop", 32'(bus.dactrigsync), 32'd0);
                resp_ack = 1'b0;
                repeat (done_dly) @(negedge clk);
                check("hold_data", 32'(bus.data), 32'(d0));
                check("hold_addr", 32'(bus.address), 32'(a0));
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [4];
        int   base;

        vecs[0] = '{ch: 2'd2, val: 12'hABC, ack_d: 3, done_d: 40, exp_addr: 4'h2, exp_data: 12'hABC};
        vecs[1] = '{ch: 2'd0, val: 12'hFFF, ack_d: 0, done_d: 1,  exp_addr: 4'h0, exp_data: 12'hFFF};
        vecs[2] = '{ch: 2'd3, val: 12'h001, ack_d: 5, done_d: 2,  exp_addr: 4'h3, exp_data: 12'h001};
        vecs[3] = '{ch: 2'd1, val: 12'h7E5, ack_d: 1, done_d: 10, exp_addr: 4'h1, exp_data: 12'h7E5};

        bus.wr_en   = 1'b0;
        bus.wr_ch   = 2'd0;
        bus.wr_data = 12'h000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_trig", 32'(bus.dactrigsync), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_addr", 32'(bus.address), 32'd0);
        check("rst_cmd", 32'(bus.command), 32'h3);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write-to-trigger latency: sampled at edge k, trigger high after edge k+1.
        push_exp(4'h0, 12'h123);
        bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 12'h123;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check("lat_trig_k", 32'(bus.dactrigsync), 32'd0);
        check("lat_pend_k", 32'(bus.pending), 32'h1);
        @(posedge clk); #1;
        check("lat_trig_k1", 32'(bus.dactrigsync), 32'd1);
        check("lat_pend_k1", 32'(bus.pending), 32'h0);
        check("lat_busy_k1", 32'(bus.busy), 32'd1);
        check("lat_data_k1", 32'(bus.data), 32'h123);
        @(negedge clk);
        wait_idle("lat_idle");

        // Single-write table.
        for (int i = 0; i < 4; i++) begin
            ack_dly  = vecs[i].ack_d;
            done_dly = vecs[i].done_d;
            base     = xfer_cnt;
            push_exp(vecs[i].exp_addr, vecs[i].exp_data);
            do_write(vecs[i].ch, vecs[i].val);
            wait_idle("vec_idle");
            check("vec_count", 32'(xfer_cnt - base), 32'd1);
            check("vec_busy", 32'(bus.busy), 32'd0);
        end

        // Back-to-back writes 0,1,3 then ch1,ch0 during ch3's transfer: round-robin gives 0 first.
        ack_dly = 2; done_dly = 20;
        base = xfer_cnt;
        push_exp(4'h0, 12'h010); push_exp(4'h1, 12'h011); push_exp(4'h3, 12'h013);
        push_exp(4'h0, 12'h020); push_exp(4'h1, 12'h021);
        do_write(2'd0, 12'h010);
        do_write(2'd1, 12'h011);
        do_write(2'd3, 12'h013);
        wait_xfers(base + 3, "rr_third");
        do_write(2'd1, 12'h021);
        do_write(2'd0, 12'h020);
        wait_idle("rr_idle");
        check("rr_count", 32'(xfer_cnt - base), 32'd5);

        // Overwrite before dispatch: last value wins, one transfer for ch1.
        base = xfer_cnt;
        push_exp(4'h0, 12'h0AA); push_exp(4'h1, 12'h200);
        do_write(2'd0, 12'h0AA);
        do_write(2'd1, 12'h100);
        do_write(2'd1, 12'h200);
        wait_idle("ovw_idle");
        check("ovw_count", 32'(xfer_cnt - base), 32'd2);

        // Write on the dispatch edge of the same channel keeps it pending.
        ack_dly = 1; done_dly = 2;
        base = xfer_cnt;
        push_exp(4'h2, 12'h111); push_exp(4'h2, 12'h222);
        do_write(2'd2, 12'h111);
        do_write(2'd2, 12'h222);
        check("edge_pend", 32'(bus.pending), 32'h4);
        wait_idle("edge_idle");
        check("edge_count", 32'(xfer_cnt - base), 32'd2);

        // Write during WAIT_DONE of the same channel: data held, then resent.
        ack_dly = 1; done_dly = 30;
        base = xfer_cnt;
        push_exp(4'h1, 12'h011); push_exp(4'h1, 12'h055);
        do_write(2'd1, 12'h011);
        wait_xfers(base + 1, "wd_first");
        repeat (4) @(negedge clk);
        check("wd_trig", 32'(bus.dactrigsync), 32'd0);
        check("wd_busy", 32'(bus.busy), 32'd1);
        do_write(2'd1, 12'h055);
        check("wd_data", 32'(bus.data), 32'h011);
        check("wd_pend", 32'(bus.pending), 32'h2);
        wait_idle("wd_idle");
        check("wd_count", 32'(xfer_cnt - base), 32'd2);

        // Manual handshake: done ignored in IDLE and TRIG.
        resp_en = 1'b0;
        pulse_done();
        check("idle_done_busy", 32'(bus.busy), 32'd0);
        check("idle_done_trig", 32'(bus.dactrigsync), 32'd0);
        do_write(2'd3, 12'h333);
        wait_trig("man_trig");
        check("man_data", 32'(bus.data), 32'h333);
        check("man_addr", 32'(bus.address), 32'h3);
        pulse_done();
        check("trig_done_busy", 32'(bus.busy), 32'd1);
        check("trig_done_trig", 32'(bus.dactrigsync), 32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("man_ack_trig", 32'(bus.dactrigsync), 32'd0);
        repeat (3) @(negedge clk);
        check("man_wait_busy", 32'(bus.busy), 32'd1);
        pulse_done();
        check("man_done_busy", 32'(bus.busy), 32'd0);

`ifdef DAC_SCHED_TIMEOUT_EN
        // Ack never arrives: abort after 16 cycles in TRIG, re-queue and retry.
        do_write(2'd0, 12'h0C0);
        wait_trig("to_trig");
        repeat (15) @(negedge clk);
        check("to_err_before", 32'(bus.err), 32'd0);
        check("to_trig_before", 32'(bus.dactrigsync), 32'd1);
        @(negedge clk);
        check("to_err", 32'(bus.err), 32'd1);
        check("to_trig_drop", 32'(bus.dactrigsync), 32'd0);
        check("to_pend", 32'(bus.pending), 32'h1);
        @(negedge clk);
        check("to_retry", 32'(bus.dactrigsync), 32'd1);
        check("to_retry_data", 32'(bus.data), 32'h0C0);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        pulse_done();
        check("to_err_sticky", 32'(bus.err), 32'd1);
        check("to_idle", 32'(bus.busy), 32'd0);
`else
        check("err_const", 32'(bus.err), 32'd0);
`endif

        // Reset during WAIT_DONE with ch2 pending: abort, nothing retried.
        do_write(2'd1, 12'h0F0);
        wait_trig("rst_seq_trig");
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        do_write(2'd2, 12'h2AA);
        check("rst_seq_pend", 32'(bus.pending), 32'h4);
        check("rst_seq_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_pend", 32'(bus.pending), 32'd0);
        check("mid_rst_trig", 32'(bus.dactrigsync), 32'd0);
        check("mid_rst_data", 32'(bus.data), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        repeat (10) @(negedge clk);
        check("no_retry_trig", 32'(bus.dactrigsync), 32'd0);
        check("no_retry_busy", 32'(bus.busy), 32'd0);

        // Normal operation resumes after reset; setpoints were cleared.
        resp_en = 1'b1;
        base = xfer_cnt;
        push_exp(4'h3, 12'h5A5);
        do_write(2'd3, 12'h5A5);
        wait_idle("post_rst_idle");
        check("post_rst_count", 32'(xfer_cnt - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
